oam_dma: RTL
============

Name: oam_dma

Overview:
- Sprite OAM DMA engine on the CPU-side bus, directly upstream of the ppu block.
- A CPU write to $4014 does three things:
  - latches a source page;
  - halts the CPU through rdy;
  - copies 256 bytes from {page,$00..$FF} to PPU register $2004 by alternating CPU-bus reads and writes.
- Runs on masterClk and advances only on CPU-cycle enable pulses.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer.
- OAM_DATA_ADDR, 16'h2004, PPU OAMDATA address written during transfer.

Ports:
- masterClk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- cpu_cen  in  1  one-masterClk pulse marking the end of each CPU cycle
- cpu_addr  in  16  CPU core address
- cpu_wr  in  1  CPU core write strobe, valid in the cycle ending at cpu_cen
- cpu_dout  in  8  CPU core write data
- bus_din  in  8  read data returned from the system bus
- rdy  out  1  1 = CPU runs, 0 = CPU halted
- dma_active  out  1  1 while the engine owns the bus
- bus_addr  out  16  address the engine drives when dma_active
- bus_rw  out  1  1 = read, 0 = write; meaningful when dma_active
- bus_dout  out  8  write data when dma_active

Behaviour:
- Reset:
  - rst low forces, immediately and independent of masterClk: state IDLE, rdy=1, dma_active=0, bus_addr=16'h0000, bus_rw=1, bus_dout=8'h00, page=0, idx=0, data latch=0, phase=0.
  - Reset mid-transfer abandons the transfer; no partial resume after rst rises.
- Clocking and phase:
  - All state changes occur on masterClk rising edges where cpu_cen=1. Outputs are registered and hold for a full CPU cycle.
  - phase toggles on every cpu_cen: 0 = get cycle, 1 = put cycle.
- Trigger:
  - In IDLE, cpu_cen & cpu_wr & cpu_addr==DMA_REG_ADDR latches page<=cpu_dout, sets idx<=0 and moves to HALT.
  - rdy drops to 0 in the same edge.
- States:
  - IDLE: rdy=1, dma_active=0.
  - HALT: one CPU cycle, dummy; dma_active=0. At its end: if the phase of the next cycle is 0, go to READ; otherwise go to ALIGN.
  - ALIGN: one CPU cycle, idle; then READ.
  - READ (phase 0): dma_active=1, bus_addr={page,idx}, bus_rw=1. At the closing cpu_cen, data latch<=bus_din; go to WRITE.
  - WRITE (phase 1): dma_active=1, bus_addr=OAM_DATA_ADDR, bus_rw=0, bus_dout=data latch. At the closing cpu_cen: if idx==8'hFF, go to IDLE; otherwise idx<=idx+1 and go to READ.
- Totals:
  - Halted duration is 513 CPU cycles when the trigger lands so that HALT is followed by a get cycle, and 514 when ALIGN is needed.
  - rdy returns to 1 in the edge that leaves the final WRITE.
- Boundaries:
  - idx is 8 bits and the transfer ends on the write for idx=$FF; there is no wrap into a 257th byte.
  - Page $20 (PPU registers) and page $40 are legal; addresses are issued verbatim with no special-casing.
  - Writes to DMA_REG_ADDR while not IDLE are ignored (no retrigger, no page change).
  - cpu_wr to any other address never affects the engine.
  - cpu_cen low: all state, including phase, holds.
  - A trigger write in the same cycle that a transfer finishes cannot occur, because the CPU is halted; no handling is required.

Optional Feature:
- Macro: OAM_DMA_CYCLE_CNT_EN.
- When defined:
  - Adds output last_cycles[9:0], reset to 0.
  - A 10-bit counter clears on trigger and increments on each cpu_cen while rdy=0.
  - On return to IDLE, last_cycles<=counter, which is 513 or 514.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-transfer:
  - Stimulus: assert rst low asynchronously between clock edges at idx=$40.
  - Response: rdy=1, dma_active=0, bus_rw=1 immediately.
  - Then: after release, no bus activity until a new $4014 write.
- Even-aligned trigger:
  - Stimulus: write $02 to $4014 with HALT followed by phase 0; bus_din returns low address byte.
  - Response: reads $0200..$02FF, each followed by a write to $2004 of the same byte; 513 halted cycles; last_cycles=513 when enabled.
- Odd-aligned trigger:
  - Stimulus: same as even-aligned but with the trigger shifted by one CPU cycle.
  - Response: one ALIGN cycle, first read at phase 0, 514 halted cycles.
- Retrigger ignored:
  - Stimulus: inject a write $07→$4014 on cpu_addr/cpu_wr during WRITE of idx=$10.
  - Response: page stays $02; transfer completes from $0211 onward.
- cpu_cen gating:
  - Stimulus: hold cpu_cen low for 5 masterClk cycles mid-READ.
  - Response: bus_addr, state and phase unchanged; capture happens only on the next cpu_cen.
- Boundary page:
  - Stimulus: write $FF to $4014.
  - Response: last read address is $FFFF, final write to $2004, then IDLE with rdy=1; no read of $0000.

Source files
------------

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a CPU write to DMA_REG_ADDR halts the CPU and copies 256 bytes {page,$00..$FF} to OAMDATA.
// Latency: trigger to first read is 2 CPU cycles (3 if an ALIGN cycle is needed); CPU is halted for 513/514 cycles.
// Backpressure: none on the bus; every state change waits for cpu_cen. Optional counter: OAM_DMA_CYCLE_CNT_EN.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        masterClk,
    input  logic        rst,
    input  logic        cpu_cen,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    input  logic [7:0]  bus_din,
    output logic        rdy,
    output logic        dma_active,
    output logic [15:0] bus_addr,
    output logic        bus_rw,
`ifdef OAM_DMA_CYCLE_CNT_EN
    output logic [9:0]  last_cycles,
`endif
    output logic [7:0]  bus_dout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic [7:0]  r_data;
    logic        r_phase;
    logic        r_rdy;
    logic        r_active;
    logic [15:0] r_addr;
    logic        r_rw;

    logic        w_trig_wr;
    logic        w_idx_last;
    logic [7:0]  w_idx_next;

    // A CPU write to the DMA register in the cycle closing at this cpu_cen
    assign w_trig_wr  = cpu_cen & cpu_wr & (cpu_addr == DMA_REG_ADDR);
    assign w_idx_last = (r_idx == 8'hFF);
    assign w_idx_next = r_idx + 8'd1;

    assign rdy        = r_rdy;
    assign dma_active = r_active;
    assign bus_addr   = r_addr;
    assign bus_rw     = r_rw;
    // The data latch is itself a register, so it drives the write data directly
    assign bus_dout   = r_data;

    // Transfer FSM: every output is registered and updated on the edge that enters the new state
    always_ff @(posedge masterClk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_page   <= 8'h00;
            r_idx    <= 8'h00;
            r_data   <= 8'h00;
            r_phase  <= 1'b0;
            r_rdy    <= 1'b1;
            r_active <= 1'b0;
            r_addr   <= 16'h0000;
            r_rw     <= 1'b1;
        end else if (cpu_cen) begin
            // get/put phase runs freely so alignment follows the real CPU cycle parity
            r_phase <= ~r_phase;
            case (r_state)
                IDLE: begin
                    if (w_trig_wr) begin
                        r_page  <= cpu_dout;
                        r_idx   <= 8'h00;
                        r_rdy   <= 1'b0;
                        r_state <= HALT;
                    end
                end
                HALT: begin
                    // r_phase is the HALT cycle's phase; the next cycle has the opposite one
                    if (r_phase) begin
                        r_active <= 1'b1;
                        r_addr   <= {r_page, r_idx};
                        r_rw     <= 1'b1;
                        r_state  <= READ;
                    end else begin
                        r_state  <= ALIGN;
                    end
                end
                ALIGN: begin
                    r_active <= 1'b1;
                    r_addr   <= {r_page, r_idx};
                    r_rw     <= 1'b1;
                    r_state  <= READ;
                end
                READ: begin
                    r_data  <= bus_din;
                    r_addr  <= OAM_DATA_ADDR;
                    r_rw    <= 1'b0;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_rw <= 1'b1;
                    if (w_idx_last) begin
                        // byte $FF was the last one; the index never wraps into a 257th read
                        r_rdy    <= 1'b1;
                        r_active <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_idx   <= w_idx_next;
                        r_addr  <= {r_page, w_idx_next};
                        r_state <= READ;
                    end
                end
                default: begin
                    r_rdy    <= 1'b1;
                    r_active <= 1'b0;
                    r_rw     <= 1'b1;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

`ifdef OAM_DMA_CYCLE_CNT_EN
    logic [9:0] r_cyc_cnt;
    logic [9:0] r_last_cycles;

    assign last_cycles = r_last_cycles;

    // Count halted CPU cycles; the final edge includes its own cycle in the published total
    always_ff @(posedge masterClk or negedge rst) begin
        if (!rst) begin
            r_cyc_cnt     <= 10'd0;
            r_last_cycles <= 10'd0;
        end else if (cpu_cen) begin
            if ((r_state == IDLE) && w_trig_wr) begin
                r_cyc_cnt <= 10'd0;
            end else if (!r_rdy) begin
                r_cyc_cnt <= r_cyc_cnt + 10'd1;
                if ((r_state == WRITE) && w_idx_last) begin
                    r_last_cycles <= r_cyc_cnt + 10'd1;
                end
            end
        end
    end
`endif

endmodule
